// File: rtl/hi_lo_mult_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hi_lo_mult_unit_if
//  Description : Operation/result bundle between the decoder/pipeline and
//                the HI/LO multiply unit.
//                master : drives ALUInstruction, Start, A, B
//                         observes Busy, Done, Hi, Lo, ReadData
//                slave  : the multiply unit itself
//  Revision    : 1.0  initial release
// ============================================================================
interface hi_lo_mult_unit_if;
  logic [4:0]  ALUInstruction;  // decoder op code
  logic        Start;           // qualifies ALUInstruction/A/B
  logic [31:0] A;               // rs operand
  logic [31:0] B;               // rt operand
  logic        Busy;            // multi-cycle op in flight
  logic        Done;            // pulse in the cycle after HI/LO update
  logic [31:0] Hi;              // HI register
  logic [31:0] Lo;              // LO register
  logic [31:0] ReadData;        // MFHI/MFLO read port

  modport master (
    output ALUInstruction, Start, A, B,
    input  Busy, Done, Hi, Lo, ReadData
  );

  modport slave (
    input  ALUInstruction, Start, A, B,
    output Busy, Done, Hi, Lo, ReadData
  );
endinterface
`default_nettype wire

// File: rtl/hi_lo_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hi_lo_mult_unit
//  Description : MIPS-style HI/LO unit. MULT/MULTU/MADD/MSUB run a 32-cycle
//                shift-add on operand magnitudes followed by one accumulate
//                cycle; MTHI/MTLO write in a single cycle; MFHI/MFLO read
//                combinationally through ReadData.
//  Ports       : Clk   - system clock, rising edge
//                Reset - synchronous, active-high
//                bus   - hi_lo_mult_unit_if.slave (op, operands, status,
//                        HI/LO and read data)
//  Revision    : 1.0  initial release
// ============================================================================
module hi_lo_mult_unit (
  input  logic                Clk,
  input  logic                Reset,
  hi_lo_mult_unit_if.slave    bus
);

  localparam logic [4:0] OP_MULT  = 5'b10110;
  localparam logic [4:0] OP_MULTU = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;
  localparam logic [4:0] OP_MFHI  = 5'b11011;
  localparam logic [4:0] OP_MFLO  = 5'b11000;

  localparam logic [4:0] LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  state_t      state_q,  state_d;
  logic [4:0]  cnt_q,    cnt_d;
  logic [4:0]  op_q,     op_d;
  logic [63:0] mcand_q,  mcand_d;   // |A|, shifted left each iteration
  logic [31:0] mplier_q, mplier_d;  // |B|, shifted right each iteration
  logic [63:0] prod_q,   prod_d;    // running magnitude product
  logic        neg_q,    neg_d;     // final product must be negated
  logic [31:0] hi_q,     hi_d;
  logic [31:0] lo_q,     lo_d;
  logic        busy_q,   busy_d;
  logic        done_q,   done_d;

  logic        w_is_mul_op;
  logic        w_is_signed_op;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [63:0] w_signed_prod;
  logic [63:0] w_hilo;

  // Operand classification and magnitudes. Negating 0x80000000 yields
  // 0x80000000, which read as unsigned is exactly 2^31, so the most
  // negative operand needs no special case.
  always_comb begin
    w_is_mul_op    = (bus.ALUInstruction == OP_MULT)  ||
                     (bus.ALUInstruction == OP_MULTU) ||
                     (bus.ALUInstruction == OP_MADD)  ||
                     (bus.ALUInstruction == OP_MSUB);
    w_is_signed_op = w_is_mul_op && (bus.ALUInstruction != OP_MULTU);
    w_a_mag        = (w_is_signed_op && bus.A[31]) ? (~bus.A + 32'd1) : bus.A;
    w_b_mag        = (w_is_signed_op && bus.B[31]) ? (~bus.B + 32'd1) : bus.B;
  end

  always_comb begin
    w_hilo        = {hi_q, lo_q};
    w_signed_prod = neg_q ? (~prod_q + 64'd1) : prod_q;
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          if (w_is_mul_op) begin
            op_d     = bus.ALUInstruction;
            mcand_d  = {32'd0, w_a_mag};
            mplier_d = w_b_mag;
            prod_d   = 64'd0;
            neg_d    = w_is_signed_op && (bus.A[31] ^ bus.B[31]);
            cnt_d    = 5'd0;
            busy_d   = 1'b1;
            state_d  = S_MUL;
          end else if (bus.ALUInstruction == OP_MTHI) begin
            hi_d   = bus.A;
            done_d = 1'b1;
          end else if (bus.ALUInstruction == OP_MTLO) begin
            lo_d   = bus.A;
            done_d = 1'b1;
          end
          // MFHI/MFLO and unknown codes leave all state untouched.
        end
      end

      S_MUL: begin
        if (mplier_q[0]) begin
          prod_d = prod_q + mcand_q;
        end
        mcand_d  = {mcand_q[62:0], 1'b0};
        mplier_d = {1'b0, mplier_q[31:1]};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          state_d = S_ACC;
        end
      end

      S_ACC: begin
        case (op_q)
          OP_MADD: {hi_d, lo_d} = w_hilo + w_signed_prod;
          OP_MSUB: {hi_d, lo_d} = w_hilo - w_signed_prod;
          default: {hi_d, lo_d} = w_signed_prod;
        endcase
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      op_q     <= 5'd0;
      mcand_q  <= 64'd0;
      mplier_q <= 32'd0;
      prod_q   <= 64'd0;
      neg_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Read port follows the live op code, not Start.
  always_comb begin
    case (bus.ALUInstruction)
      OP_MFHI: bus.ReadData = hi_q;
      OP_MFLO: bus.ReadData = lo_q;
      default: bus.ReadData = 32'd0;
    endcase
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_hi_lo_mult_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hi_lo_mult_unit
//  Description : Directed bench for hi_lo_mult_unit with hand-computed
//                expected HI/LO values, Busy length and Done pulse counts.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hi_lo_mult_unit;

  localparam logic [4:0] OP_NONE  = 5'b00000;
  localparam logic [4:0] OP_MULT  = 5'b10110;
  localparam logic [4:0] OP_MULTU = 5'b10011;
  localparam logic [4:0] OP_MADD  = 5'b10100;
  localparam logic [4:0] OP_MSUB  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b11001;
  localparam logic [4:0] OP_MTLO  = 5'b11010;
  localparam logic [4:0] OP_MFHI  = 5'b11011;
  localparam logic [4:0] OP_MFLO  = 5'b11000;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_pass;

  hi_lo_mult_unit_if bus ();

  hi_lo_mult_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Advance one cycle; outputs are then sampled 1ns after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Start          = 1'b0;
    bus.ALUInstruction = OP_NONE;
    bus.A              = 32'd0;
    bus.B              = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  // Single-cycle MTHI/MTLO.
  task automatic move_to(input string tag, input logic [4:0] op, input logic [31:0] a);
    bus.ALUInstruction = op;
    bus.A              = a;
    bus.Start          = 1'b1;
    tick();
    idle_inputs();
    check({tag, "_busy"}, {63'd0, bus.Busy}, 64'd0);
    check({tag, "_done"}, {63'd0, bus.Done}, 64'd1);
  endtask

  // Full multiply: checks busy length, held HI/LO during busy, Done pulse and result.
  task automatic run_mul(input string tag, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_pre, input logic [63:0] exp_res);
    int n;
    bus.ALUInstruction = op;
    bus.A              = a;
    bus.B              = b;
    bus.Start          = 1'b1;
    tick();
    idle_inputs();
    check({tag, "_hold"}, {bus.Hi, bus.Lo}, exp_pre);
    n = 0;
    while (bus.Busy && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_busylen"}, 64'(n), 64'd33);
    check({tag, "_done"}, {63'd0, bus.Done}, 64'd1);
    check({tag, "_result"}, {bus.Hi, bus.Lo}, exp_res);
    tick();
    check({tag, "_done_off"}, {63'd0, bus.Done}, 64'd0);
  endtask

  initial begin
    int ndone;
    n_checks = 0;
    n_pass   = 0;
    idle_inputs();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;

    // Reset state
    check("rst_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("rst_busy", {63'd0, bus.Busy}, 64'd0);
    check("rst_done", {63'd0, bus.Done}, 64'd0);
    check("rst_rdata", {32'd0, bus.ReadData}, 64'd0);

    // Signed -1 * 2
    run_mul("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002,
            64'd0, 64'hFFFF_FFFF_FFFF_FFFE);
    // Unsigned max squared
    run_mul("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFE_0000_0001);
    // -2^31 squared
    run_mul("mult_min", OP_MULT, 32'h8000_0000, 32'h8000_0000,
            64'hFFFF_FFFE_0000_0001, 64'h4000_0000_0000_0000);
    // -3 * 7 = -21
    run_mul("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007,
            64'h4000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFEB);

    // MTHI/MTLO then MADD
    move_to("mthi", OP_MTHI, 32'h1234_5678);
    check("mthi_hi", {32'd0, bus.Hi}, 64'h1234_5678);
    move_to("mtlo", OP_MTLO, 32'h0000_0001);
    check("mtlo_hilo", {bus.Hi, bus.Lo}, 64'h1234_5678_0000_0001);
    run_mul("madd", OP_MADD, 32'd3, 32'd4,
            64'h1234_5678_0000_0001, 64'h1234_5678_0000_000D);

    // MFHI/MFLO read port; Start with MFHI changes nothing
    bus.ALUInstruction = OP_MFHI;
    bus.Start          = 1'b1;
    #1;
    check("mfhi_rdata", {32'd0, bus.ReadData}, 64'h1234_5678);
    tick();
    check("mfhi_nodone", {63'd0, bus.Done}, 64'd0);
    check("mfhi_hilo", {bus.Hi, bus.Lo}, 64'h1234_5678_0000_000D);
    bus.ALUInstruction = OP_MFLO;
    bus.Start          = 1'b0;
    #1;
    check("mflo_rdata", {32'd0, bus.ReadData}, 64'h0000_000D);
    idle_inputs();
    #1;
    check("none_rdata", {32'd0, bus.ReadData}, 64'd0);

    // Unknown op code is ignored
    bus.ALUInstruction = 5'b00111;
    bus.A              = 32'hDEAD_BEEF;
    bus.Start          = 1'b1;
    tick();
    idle_inputs();
    check("badop_busy", {63'd0, bus.Busy}, 64'd0);
    check("badop_done", {63'd0, bus.Done}, 64'd0);
    check("badop_hilo", {bus.Hi, bus.Lo}, 64'h1234_5678_0000_000D);

    // Reset beats Start in the same cycle
    bus.ALUInstruction = OP_MTHI;
    bus.A              = 32'hCAFE_F00D;
    bus.Start          = 1'b1;
    Reset              = 1'b1;
    tick();
    Reset = 1'b0;
    idle_inputs();
    check("rstprio_hilo", {bus.Hi, bus.Lo}, 64'd0);
    check("rstprio_done", {63'd0, bus.Done}, 64'd0);

    // MSUB wraps from zero
    run_mul("msub_wrap", OP_MSUB, 32'd1, 32'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);

    // Start during busy ignored, operands toggling
    do_reset();
    bus.ALUInstruction = OP_MULT;
    bus.A              = 32'd5;
    bus.B              = 32'd6;
    bus.Start          = 1'b1;
    tick();
    ndone = 0;
    for (int cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 5) begin
        bus.Start = 1'b1;
        bus.A     = 32'd7;
        bus.B     = 32'd7;
      end else begin
        bus.Start = 1'b0;
        bus.A     = ~bus.A;
        bus.B     = ~bus.B;
      end
      tick();
      if (bus.Done) ndone++;
    end
    idle_inputs();
    check("busystart_done_cnt", 64'(ndone), 64'd1);
    check("busystart_result", {bus.Hi, bus.Lo}, 64'h0000_0000_0000_001E);
    check("busystart_idle", {63'd0, bus.Busy}, 64'd0);

    // Back-to-back: new Start accepted in the Done cycle
    bus.ALUInstruction = OP_MULTU;
    bus.A              = 32'd2;
    bus.B              = 32'd3;
    bus.Start          = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int i = 0; i < 33; i++) tick();
    check("b2b_first_done", {63'd0, bus.Done}, 64'd1);
    bus.ALUInstruction = OP_MADD;
    bus.A              = 32'hFFFF_FFFF;
    bus.B              = 32'd4;
    bus.Start          = 1'b1;
    tick();
    idle_inputs();
    check("b2b_second_busy", {63'd0, bus.Busy}, 64'd1);
    for (int i = 0; i < 33; i++) tick();
    check("b2b_second_done", {63'd0, bus.Done}, 64'd1);
    check("b2b_result", {bus.Hi, bus.Lo}, 64'h0000_0000_0000_0002);

    // Reset in the middle of an operation
    move_to("pre_abort_mthi", OP_MTHI, 32'h0000_DEAD);
    bus.ALUInstruction = OP_MULT;
    bus.A              = 32'd5;
    bus.B              = 32'd6;
    bus.Start          = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i < 9; i++) tick();
    check("abort_prebusy", {63'd0, bus.Busy}, 64'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("abort_busy", {63'd0, bus.Busy}, 64'd0);
    check("abort_hilo", {bus.Hi, bus.Lo}, 64'd0);
    ndone = (bus.Done) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.Done) ndone++;
    end
    check("abort_nodone", 64'(ndone), 64'd0);
    check("abort_hilo_late", {bus.Hi, bus.Lo}, 64'd0);
    move_to("post_abort_mtlo", OP_MTLO, 32'hA5A5_A5A5);
    check("post_abort_lo", {bus.Hi, bus.Lo}, 64'h0000_0000_A5A5_A5A5);
    tick();
    check("post_abort_done_off", {63'd0, bus.Done}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hi_lo_mult_unit.md
HI_LO_MULT_UNIT -- requirements
Module: hi_lo_mult_unit

Interface
REQ-001 Clk  input  1  system clock; all state changes on its rising edge.
REQ-002 Reset  input  1  synchronous, active-high reset.
REQ-003 ALUInstruction  input  5  op code from the decoder: 10110 MULT, 10011 MULTU, 10100 MADD, 10101 MSUB, 11001 MTHI, 11010 MTLO, 11011 MFHI, 11000 MFLO.
REQ-004 Start  input  1  operation-valid qualifier for ALUInstruction/A/B, sampled on each rising edge.
REQ-005 A  input  32  rs operand.
REQ-006 B  input  32  rt operand.
REQ-007 Busy  output  1  multi-cycle operation in progress; the pipeline stalls while it is high.
REQ-008 Done  output  1  registered, one-cycle pulse in the cycle after HI/LO are updated.
REQ-009 Hi  output  32  registered HI register.
REQ-010 Lo  output  32  registered LO register.
REQ-011 ReadData  output  32  combinational: Hi when ALUInstruction=11011, Lo when 11000, else 0.

Function
REQ-012 The FSM SHALL have three states:
- IDLE: accepts new operations.
- MUL: 32 iterations, one multiplier bit per cycle, shift-add on operand magnitudes.
- ACC: a single cycle that writes or accumulates HI/LO.
REQ-013 In IDLE with Start=1 and a multiply op (MULT/MULTU/MADD/MSUB), the rising edge E0 SHALL latch A, B and the op, clear the iteration counter, and enter MUL.
REQ-014 MUL SHALL last exactly 32 edges (E1..E32) and then go to ACC.
REQ-015 The edge out of ACC (E33) SHALL update {Hi,Lo} and return to IDLE.
REQ-016 Busy SHALL be 1 from the cycle after E0 through the cycle ending at E33 (33 cycles), and 0 otherwise.
REQ-017 Done SHALL be 1 for exactly the one cycle following E33.
REQ-018 MULT SHALL set {Hi,Lo} = signed(A) x signed(B) as a 64-bit result.
REQ-019 MULTU SHALL set {Hi,Lo} = unsigned(A) x unsigned(B) as a 64-bit result.
REQ-020 MADD SHALL set {Hi,Lo} = {Hi,Lo} + signed product, modulo 2^64.
REQ-021 MSUB SHALL set {Hi,Lo} = {Hi,Lo} - signed product, modulo 2^64.
REQ-022 Signed ops SHALL multiply magnitudes and negate the 64-bit product (two's complement) when sign(A) XOR sign(B) is 1; -2^31 operands SHALL produce exact results.
REQ-023 In IDLE with Start=1, MTHI SHALL write Hi=A and MTLO SHALL write Lo=A on that edge; Busy SHALL stay 0; Done SHALL pulse the following cycle.
REQ-024 MFHI/MFLO SHALL not change state, not assert Done, and not depend on Start.
REQ-025 Start while Busy=1 SHALL be ignored (no queueing, no effect on the result in flight, no extra Done).
REQ-026 Start with any op code not listed in REQ-003 SHALL be ignored.
REQ-027 Changes on A/B/ALUInstruction during Busy SHALL NOT affect the result, because the operands were latched at E0.
REQ-028 During Busy, Hi/Lo and ReadData SHALL show the pre-operation values.
REQ-029 A new Start SHALL be accepted in the Done cycle (back-to-back, no bubble).

Reset
REQ-030 Reset=1 at a rising edge SHALL force state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, iteration counter=0, and clear the latched operands.
REQ-031 Reset SHALL take priority over Start in the same cycle.
REQ-032 Reset mid-operation SHALL abort the operation with no Done pulse and no HI/LO update.

Verification
REQ-033 Reset; MULT A=0xFFFFFFFF, B=0x00000002 -> Busy high 33 cycles; then Hi=0xFFFFFFFF, Lo=0xFFFFFFFE; Done pulses once.
REQ-034 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001; MULT A=0x80000000, B=0x80000000 -> Hi=0x40000000, Lo=0x00000000.
REQ-035 MTHI A=0x12345678; MTLO A=0x00000001; MADD A=3, B=4 -> Hi=0x12345678, Lo=0x0000000D; MFHI gives ReadData=0x12345678.
REQ-036 From Hi=Lo=0, MSUB A=1, B=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF (wrap).
REQ-037 MULT A=5, B=6, then Start MULT A=7, B=7 at busy cycle 5, with A/B toggled every cycle -> Lo=0x0000001E, Hi=0; exactly one Done.
REQ-038 Reset asserted at busy cycle 10 -> next cycle Busy=0, Hi=Lo=0, no Done; then MTLO A=0xA5A5A5A5 -> Lo=0xA5A5A5A5, Done one cycle later.
